clock_enable_gen: RTL

CLOCK_ENABLE_GEN -- requirements
Module: clock_enable_gen

---
 rtl/clock_enable_gen_pkg.sv | 18 +
 rtl/clk_phase_acc.sv | 43 ++++
 rtl/clock_enable_gen.sv | 110 +++++++++++
 3 files changed

// File: rtl/clock_enable_gen_pkg.sv
// Shared types and constants for the clock-enable generator: FSM state encoding,
// default accumulator width and the hold-counter width helper.
package clock_enable_gen_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int ACC_W_DEFAULT = 16;

    // The counter only has to reach LOCK_HOLD-1; never narrower than one bit.
    function automatic int hold_cnt_w(input int lock_hold);
        return (lock_hold > 1) ? $clog2(lock_hold) : 1;
    endfunction

endpackage

// File: rtl/clk_phase_acc.sv
// One clock-enable channel: phase accumulator, carry-out strobe and a square
// wave taken from the registered accumulator MSB.
module clk_phase_acc
    import clock_enable_gen_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_run,
    input  logic [ACC_W-1:0] i_inc,
    output logic             o_strobe,
    output logic             o_clk_out
);

    logic [ACC_W-1:0] r_acc;
    logic             r_strobe;
    logic             r_clk_out;
    logic [ACC_W:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, i_inc};

    // Accumulate while running; the carry out of the top bit becomes the strobe.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc     <= '0;
            r_strobe  <= 1'b0;
            r_clk_out <= 1'b0;
        end else if (!i_run) begin
            r_acc     <= '0;
            r_strobe  <= 1'b0;
            r_clk_out <= 1'b0;
        end else begin
            r_acc     <= w_sum[ACC_W-1:0];
            r_strobe  <= w_sum[ACC_W];
            r_clk_out <= r_acc[ACC_W-1];
        end
    end

    assign o_strobe  = r_strobe;
    assign o_clk_out = r_clk_out;

endmodule

// File: rtl/clock_enable_gen.sv
// Lock-qualified reset sequencer plus NUM_CH independent phase-accumulator
// clock-enable channels, all in the PLL output clock domain.
module clock_enable_gen
    import clock_enable_gen_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int ACC_W     = ACC_W_DEFAULT,
    parameter int LOCK_HOLD = 1024
) (
    input  logic                    clock_in,
    input  logic                    reset,
    input  logic                    locked,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH*ACC_W-1:0] inc,
    output logic                    rst_out,
    output logic                    ready,
    output logic [NUM_CH-1:0]       strobe,
    output logic [NUM_CH-1:0]       clk_out
);

    localparam int               CNT_W    = hold_cnt_w(LOCK_HOLD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_HOLD - 1);

    logic             r_sync1;
    logic             r_lock_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rst_out;
    logic             r_ready;
    logic             w_run;

    // Two-flop synchroniser for the asynchronous PLL lock flag.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_sync1  <= locked;
            r_lock_s <= r_sync1;
        end
    end

    // Lock sequencer; rst_out/ready are registered alongside the state.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_state   <= WAIT_LOCK;
            r_cnt     <= '0;
            r_rst_out <= 1'b1;
            r_ready   <= 1'b0;
        end else begin
            r_rst_out <= 1'b1;
            r_ready   <= 1'b0;
            case (r_state)
                WAIT_LOCK: begin
                    r_cnt <= '0;
                    if (r_lock_s) begin
                        r_state <= HOLD;
                    end else begin
                        r_state <= WAIT_LOCK;
                    end
                end
                HOLD: begin
                    if (!r_lock_s) begin
                        r_state <= WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= RUN;
                        r_rst_out <= 1'b0;
                        r_ready   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1'b1);
                    end
                end
                RUN: begin
                    if (!r_lock_s) begin
                        r_state <= WAIT_LOCK;
                        r_cnt   <= '0;
                    end else begin
                        r_rst_out <= 1'b0;
                        r_ready   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= WAIT_LOCK;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Qualifying with lock_s lets channels clear on the same edge the FSM leaves RUN.
    assign w_run = (r_state == RUN) && r_lock_s;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_phase_acc #(
            .ACC_W(ACC_W)
        ) u_ch (
            .i_clk    (clock_in),
            .i_reset  (reset),
            .i_run    (w_run && enable[g]),
            .i_inc    (inc[g*ACC_W +: ACC_W]),
            .o_strobe (strobe[g]),
            .o_clk_out(clk_out[g])
        );
    end

    assign rst_out = r_rst_out;
    assign ready   = r_ready;

endmodule
